darkroom_spi_receiver: RTL and testbench

- SPI slave that receives the 256-bit lighthouse sensor frames sent by the DarkRoom SPI transmitter (mode 0, 8-bit bytes, slave select framed).
- Deserialises and validates each frame, double-buffers it, then streams it out as eight 32-bit sensor words over a valid/ready interface.
- Sits on the receiving board (test rig or ESP-side FPGA bridge) and feeds decoded lighthouse data to the downstream logic.

---
 rtl/darkroom_spi_receiver.sv | 221 ++++++++++++++++++++++
 tb/tb_darkroom_spi_receiver.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/darkroom_spi_receiver.sv
`default_nettype none
// ============================================================================
// Module      : darkroom_spi_receiver
// Description : SPI mode-0 slave for DarkRoom lighthouse sensor frames.
//               It synchronises the SPI pins into clk and shifts in one
//               frame per slave-select window. Each frame is validated on
//               slave-select release. A good frame is copied into an output
//               buffer and streamed out as FRAME_BITS/WORD_WIDTH sensor words
//               over a valid/ready handshake.
// Ports       : clk, rst            - system clock, async active-high reset
//               sck_i/ss_n_i/mosi_i - raw SPI pins, asynchronous to clk
//               word_o/word_index_o - current sensor word and its index
//               word_valid_o        - word/index valid
//               word_ready_i        - downstream accepts word when high
//               frame_done_o        - pulse on acceptance of the last word
//               frame_count_o       - good frames received (wrapping)
//               error_count_o       - rejected frames (saturating)
//               busy_o              - synchronised slave select active
// Revision    : 1.0 - initial release
// ============================================================================
module darkroom_spi_receiver #(
  parameter int FRAME_BITS  = 256,
  parameter int WORD_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck_i,
  input  logic                  ss_n_i,
  input  logic                  mosi_i,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic [2:0]            word_index_o,
  output logic                  word_valid_o,
  input  logic                  word_ready_i,
  output logic                  frame_done_o,
  output logic [15:0]           frame_count_o,
  output logic [15:0]           error_count_o,
  output logic                  busy_o
);

  localparam int NUM_WORDS = FRAME_BITS / WORD_WIDTH;
  localparam int CNT_W     = $clog2(FRAME_BITS + 2);
  localparam int POS_W     = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] C_CNT_SAT  = CNT_W'(FRAME_BITS + 1);
  localparam logic [2:0]       C_LAST_IDX = 3'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_CHECK = 2'd2
  } rx_state_t;

  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_SEND  = 1'b1
  } out_state_t;

  // Synchroniser chains: index 0 is the first stage, SYNC_STAGES-1 the last.
  logic [SYNC_STAGES-1:0] sck_sync_q,  sck_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q,   ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  // Tracks which synchroniser stages hold a real post-reset sample.
  logic [SYNC_STAGES-1:0] fill_q,      fill_d;
  // Set once slave select has been seen idle after reset. A transfer already
  // in progress when reset is released must never be joined mid-stream.
  logic                   armed_q,     armed_d;

  rx_state_t              rx_state_q,  rx_state_d;
  logic [CNT_W-1:0]       bit_cnt_q,   bit_cnt_d;
  logic [FRAME_BITS-1:0]  shift_q,     shift_d;

  out_state_t             out_state_q, out_state_d;
  logic [2:0]             idx_q,       idx_d;
  logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] out_buf_q, out_buf_d;

  logic [15:0]            frame_count_q, frame_count_d;
  logic [15:0]            error_count_q, error_count_d;

  logic                   sck_rise;
  logic                   ss_fall;
  logic                   ss_rise;
  logic                   mosi_bit;
  logic [POS_W-1:0]       bit_pos;
  logic                   start_out;
  logic                   bump_err;
  logic                   accept;

  assign sck_rise = sck_sync_q[SYNC_STAGES-2] & ~sck_sync_q[SYNC_STAGES-1];
  assign ss_fall  = ~ss_sync_q[SYNC_STAGES-2] &  ss_sync_q[SYNC_STAGES-1];
  assign ss_rise  =  ss_sync_q[SYNC_STAGES-2] & ~ss_sync_q[SYNC_STAGES-1];
  assign mosi_bit = mosi_sync_q[SYNC_STAGES-1];

  // MSB-first within a byte, byte k at [8k+7:8k]: invert the low three bits.
  assign bit_pos  = {bit_cnt_q[POS_W-1:3], ~bit_cnt_q[2:0]};

  assign accept   = (out_state_q == OUT_SEND) && word_ready_i;

  always_comb begin
    sck_sync_d    = {sck_sync_q[SYNC_STAGES-2:0],  sck_i};
    ss_sync_d     = {ss_sync_q[SYNC_STAGES-2:0],   ss_n_i};
    mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
    fill_d        = {fill_q[SYNC_STAGES-2:0],      1'b1};
    armed_d       = armed_q | (fill_q[SYNC_STAGES-1] & ss_sync_q[SYNC_STAGES-1]);

    rx_state_d    = rx_state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    out_state_d   = out_state_q;
    idx_d         = idx_q;
    out_buf_d     = out_buf_q;
    frame_count_d = frame_count_q;
    error_count_d = error_count_q;
    start_out     = 1'b0;
    bump_err      = 1'b0;

    // Receive path
    case (rx_state_q)
      RX_IDLE: begin
        if (ss_fall && armed_q) begin
          bit_cnt_d  = '0;
          rx_state_d = RX_SHIFT;
        end
      end
      RX_SHIFT: begin
        // A coincident sck rise and ss rise still captures the bit first.
        if (sck_rise) begin
          if (bit_cnt_q < C_CNT_FULL) begin
            shift_d[bit_pos] = mosi_bit;
          end
          if (bit_cnt_q != C_CNT_SAT) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        if (ss_rise) begin
          rx_state_d = RX_CHECK;
        end
      end
      RX_CHECK: begin
        rx_state_d = RX_IDLE;
        if (bit_cnt_q == C_CNT_FULL && out_state_q == OUT_EMPTY) begin
          out_buf_d     = shift_q;
          frame_count_d = frame_count_q + 16'd1;
          start_out     = 1'b1;
        end else begin
          // Wrong length, or previous frame still draining (overrun).
          bump_err = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    if (bump_err && error_count_q != 16'hFFFF) begin
      error_count_d = error_count_q + 16'd1;
    end

    // Output path
    case (out_state_q)
      OUT_EMPTY: begin
        if (start_out) begin
          out_state_d = OUT_SEND;
          idx_d       = 3'd0;
        end
      end
      OUT_SEND: begin
        if (accept) begin
          if (idx_q == C_LAST_IDX) begin
            out_state_d = OUT_EMPTY;
            idx_d       = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: out_state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q    <= '0;
      ss_sync_q     <= '1;
      mosi_sync_q   <= '0;
      fill_q        <= '0;
      armed_q       <= 1'b0;
      rx_state_q    <= RX_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      out_state_q   <= OUT_EMPTY;
      idx_q         <= 3'd0;
      out_buf_q     <= '0;
      frame_count_q <= 16'd0;
      error_count_q <= 16'd0;
    end else begin
      sck_sync_q    <= sck_sync_d;
      ss_sync_q     <= ss_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      fill_q        <= fill_d;
      armed_q       <= armed_d;
      rx_state_q    <= rx_state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      out_state_q   <= out_state_d;
      idx_q         <= idx_d;
      out_buf_q     <= out_buf_d;
      frame_count_q <= frame_count_d;
      error_count_q <= error_count_d;
    end
  end

  assign word_o        = out_buf_q[idx_q];
  assign word_index_o  = idx_q;
  assign word_valid_o  = (out_state_q == OUT_SEND);
  assign frame_done_o  = accept && (idx_q == C_LAST_IDX);
  assign frame_count_o = frame_count_q;
  assign error_count_o = error_count_q;
  assign busy_o        = ~ss_sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_darkroom_spi_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_darkroom_spi_receiver
// Description : Directed scoreboard bench for darkroom_spi_receiver. Frames
//               are shifted in over SPI mode 0. The words each frame should
//               produce are queued, and a monitor pops and compares every
//               accepted word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_darkroom_spi_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck_i = 1'b0;
  logic        ss_n_i = 1'b1;
  logic        mosi_i = 1'b0;
  logic        word_ready_i = 1'b0;
  logic [31:0] word_o;
  logic [2:0]  word_index_o;
  logic        word_valid_o;
  logic        frame_done_o;
  logic [15:0] frame_count_o;
  logic [15:0] error_count_o;
  logic        busy_o;

  darkroom_spi_receiver #(
    .FRAME_BITS (256),
    .WORD_WIDTH (32),
    .SYNC_STAGES(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sck_i        (sck_i),
    .ss_n_i       (ss_n_i),
    .mosi_i       (mosi_i),
    .word_o       (word_o),
    .word_index_o (word_index_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .frame_done_o (frame_done_o),
    .frame_count_o(frame_count_o),
    .error_count_o(error_count_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [34:0] exp_q[$];          // {index, word}
  logic [7:0]  fb[0:32];
  int          ready_mode = 0;    // 0: always, 1: every third cycle, 2: never
  int          cyc = 0;
  int          done_cnt = 0;
  int          first_acc = 0;
  int          last_acc = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_word = '0;
  logic [2:0]  hold_idx = '0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    case (ready_mode)
      0:       word_ready_i = 1'b1;
      1:       word_ready_i = (cyc % 3 == 0);
      default: word_ready_i = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every accepted word.
  always @(negedge clk) begin
    logic [34:0] e;
    if (hold_prev && word_valid_o) begin
      vectors = vectors + 1;
      if (word_o !== hold_word || word_index_o !== hold_idx) begin
        miscompares = miscompares + 1;
        $display("FAIL hold: got idx %0d word %h, held idx %0d word %h",
                 word_index_o, word_o, hold_idx, hold_word);
      end
    end
    hold_prev = word_valid_o && !word_ready_i;
    hold_word = word_o;
    hold_idx  = word_index_o;
    if (word_valid_o && word_ready_i) begin
      vectors = vectors + 1;
      if (exp_q.size() == 0) begin
        miscompares = miscompares + 1;
        $display("FAIL unexpected_word: got idx %0d word %h, none expected",
                 word_index_o, word_o);
      end else begin
        e = exp_q.pop_front();
        if ({word_index_o, word_o} !== e) begin
          miscompares = miscompares + 1;
          $display("FAIL word: got idx %0d word %h, expected idx %0d word %h",
                   word_index_o, word_o, e[34:32], e[31:0]);
        end
      end
      vectors = vectors + 1;
      if (frame_done_o !== (word_index_o == 3'd7)) begin
        miscompares = miscompares + 1;
        $display("FAIL frame_done: got %b at idx %0d, expected %b",
                 frame_done_o, word_index_o, (word_index_o == 3'd7));
      end
      if (word_index_o == 3'd0) first_acc = cyc;
      if (word_index_o == 3'd7) last_acc = cyc;
    end else if (frame_done_o) begin
      vectors = vectors + 1;
      miscompares = miscompares + 1;
      $display("FAIL frame_done_spurious: got 1 without acceptance, expected 0");
    end
    if (frame_done_o) done_cnt = done_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic spi_begin();
    ss_n_i = 1'b0;
    #80;
  endtask

  task automatic spi_bits(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      mosi_i = fb[i / 8][7 - (i % 8)];
      #40 sck_i = 1'b1;
      #40 sck_i = 1'b0;
    end
  endtask

  task automatic spi_end();
    #40 ss_n_i = 1'b1;
    #200;
  endtask

  task automatic push_frame();
    for (int n = 0; n < 8; n++) begin
      exp_q.push_back({3'(n), fb[4*n+3], fb[4*n+2], fb[4*n+1], fb[4*n]});
    end
  endtask

  task automatic fill_ramp(input logic [7:0] base);
    for (int k = 0; k < 33; k++) fb[k] = base + 8'(k);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || word_valid_o) && k < 3000) begin
      @(posedge clk);
      k++;
    end
    vectors = vectors + 1;
    if (k >= 3000) begin
      miscompares = miscompares + 1;
      $display("FAIL drain_timeout: got %0d words pending, expected 0", exp_q.size());
    end
    repeat (10) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(word_valid_o), 32'd0);
    check("reset_word", word_o, 32'd0);
    check("reset_index", 32'(word_index_o), 32'd0);
    check("reset_done", 32'(frame_done_o), 32'd0);
    check("reset_frames", 32'(frame_count_o), 32'd0);
    check("reset_errors", 32'(error_count_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Basic frame, ready always high
    ready_mode = 0;
    fill_ramp(8'h00);
    exp_q.push_back({3'd0, 32'h03020100});
    exp_q.push_back({3'd1, 32'h07060504});
    exp_q.push_back({3'd2, 32'h0B0A0908});
    exp_q.push_back({3'd3, 32'h0F0E0D0C});
    exp_q.push_back({3'd4, 32'h13121110});
    exp_q.push_back({3'd5, 32'h17161514});
    exp_q.push_back({3'd6, 32'h1B1A1918});
    exp_q.push_back({3'd7, 32'h1F1E1D1C});
    spi_begin();
    check("busy_in_frame", 32'(busy_o), 32'd1);
    spi_bits(256);
    spi_end();
    wait_drain();
    check("basic_frames", 32'(frame_count_o), 32'd1);
    check("basic_errors", 32'(error_count_o), 32'd0);
    check("basic_done_pulses", 32'(done_cnt), 32'd1);
    check("basic_consecutive", 32'(last_acc - first_acc), 32'd7);

    // Backpressure: ready every third cycle
    do_reset();
    ready_mode = 1;
    done_cnt = 0;
    push_frame();
    spi_begin();
    spi_bits(256);
    spi_end();
    wait_drain();
    check("bp_frames", 32'(frame_count_o), 32'd1);
    check("bp_done_pulses", 32'(done_cnt), 32'd1);

    // Short frame (255 bits), then a good frame
    do_reset();
    ready_mode = 0;
    spi_begin();
    spi_bits(255);
    spi_end();
    repeat (20) @(negedge clk);
    check("short_errors", 32'(error_count_o), 32'd1);
    check("short_frames", 32'(frame_count_o), 32'd0);
    fill_ramp(8'h80);
    push_frame();
    spi_begin();
    spi_bits(256);
    spi_end();
    wait_drain();
    check("after_short_frames", 32'(frame_count_o), 32'd1);
    check("after_short_errors", 32'(error_count_o), 32'd1);

    // Long frame (257 bits)
    do_reset();
    fill_ramp(8'h20);
    spi_begin();
    spi_bits(257);
    spi_end();
    repeat (20) @(negedge clk);
    check("long_errors", 32'(error_count_o), 32'd1);
    check("long_frames", 32'(frame_count_o), 32'd0);

    // Overrun: ready held low across two frames
    do_reset();
    ready_mode = 2;
    fill_ramp(8'h40);
    push_frame();
    spi_begin();
    spi_bits(256);
    spi_end();
    fill_ramp(8'hC0);
    spi_begin();
    spi_bits(256);
    spi_end();
    repeat (20) @(negedge clk);
    check("ovr_valid", 32'(word_valid_o), 32'd1);
    check("ovr_word0", word_o, 32'h43424140);
    check("ovr_index0", 32'(word_index_o), 32'd0);
    check("ovr_errors", 32'(error_count_o), 32'd1);
    check("ovr_frames", 32'(frame_count_o), 32'd1);
    ready_mode = 0;
    wait_drain();
    repeat (50) @(negedge clk);
    check("ovr_no_extra", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset after 100 bits, then an 0xA5 frame
    fill_ramp(8'h10);
    spi_begin();
    spi_bits(100);
    #13 rst = 1'b1;
    #1;
    check("arst_valid", 32'(word_valid_o), 32'd0);
    check("arst_frames", 32'(frame_count_o), 32'd0);
    check("arst_errors", 32'(error_count_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    #50 rst = 1'b0;
    spi_bits(20);
    spi_end();
    repeat (20) @(negedge clk);
    check("arst_partial_errors", 32'(error_count_o), 32'd0);
    check("arst_partial_frames", 32'(frame_count_o), 32'd0);
    for (int k = 0; k < 33; k++) fb[k] = 8'hA5;
    exp_q.push_back({3'd0, 32'hA5A5A5A5});
    for (int n = 1; n < 8; n++) exp_q.push_back({3'(n), 32'hA5A5A5A5});
    spi_begin();
    spi_bits(256);
    spi_end();
    wait_drain();
    check("a5_frames", 32'(frame_count_o), 32'd1);
    check("a5_errors", 32'(error_count_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
